// File: rtl/fetch_pkg.sv
// Shared types for the fetch/decode boundary.
package fetch_pkg;

  // Control word handed from fetch to decode; fetch fills only pc and inst.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        mem_re;
    logic        mem_we;
    logic        branch;
    logic        jump;
  } rvga_cword;

endpackage

// File: rtl/fetch.sv
// Instruction fetch stage: single-outstanding imem requests, small {pc, inst}
// buffer, registered output to decode, redirect flush with wrong-path kill.
// Optional performance counters are built when IF_PERF_EN is defined.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output rvga_cword   if_de_cword,
  output logic        if_de_valid,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(BUF_DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_KILL = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [31:0]      r_fetch_pc;
  logic [31:0]      w_fetch_pc_nxt;
  logic             r_req;
  logic             w_req_nxt;
  logic [31:0]      r_addr;
  logic [31:0]      w_addr_nxt;
  logic             w_push;
  logic             w_pop;
  logic             w_have_head;
  logic [31:0]      w_redirect_aligned;

  logic [31:0]      r_buf_pc   [BUF_DEPTH];
  logic [31:0]      r_buf_inst [BUF_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic [31:0]      r_out_pc;
  logic [31:0]      r_out_inst;
  logic             r_out_valid;

  assign w_redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
  assign w_have_head        = (r_count != '0);
  assign w_pop              = !stall && !redirect_valid && w_have_head;

  // Fetch FSM state and request registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RESET_PC;
      r_req      <= 1'b0;
      r_addr     <= RESET_PC;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_req      <= w_req_nxt;
      r_addr     <= w_addr_nxt;
    end
  end

  // Next-state, next-request and push decision; redirect overrides everything.
  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_req_nxt      = r_req;
    w_addr_nxt     = r_addr;
    w_push         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (r_count < DEPTH_C) begin
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_fetch_pc;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_ack) begin
          w_push         = 1'b1;
          w_fetch_pc_nxt = r_fetch_pc + 32'd4;
          w_req_nxt      = 1'b0;
          w_state_nxt    = S_IDLE;
        end
      end
      S_KILL: begin
        if (imem_ack) begin
          w_req_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase

    if (redirect_valid) begin
      w_push         = 1'b0;
      w_fetch_pc_nxt = w_redirect_aligned;
      // An ack in the redirect cycle retires the old request; otherwise it is killed.
      if ((r_state == S_WAIT || r_state == S_KILL) && !imem_ack) begin
        w_req_nxt   = 1'b1;
        w_state_nxt = S_KILL;
      end else begin
        w_req_nxt   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    end
  end

  // Buffer pointers and occupancy; redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Buffer storage; a push into a full buffer reuses the slot being popped.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_buf_pc[r_wr_ptr]   <= r_fetch_pc;
      r_buf_inst[r_wr_ptr] <= imem_rdata;
    end
  end

  // Output register: pop head or load a bubble; redirect forces a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_pc    <= '0;
      r_out_inst  <= NOP_INST;
      r_out_valid <= 1'b0;
    end else if (redirect_valid || (!stall && !w_have_head)) begin
      r_out_pc    <= '0;
      r_out_inst  <= NOP_INST;
      r_out_valid <= 1'b0;
    end else if (!stall) begin
      r_out_pc    <= r_buf_pc[r_rd_ptr];
      r_out_inst  <= r_buf_inst[r_rd_ptr];
      r_out_valid <= 1'b1;
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_addr;
  assign if_de_valid = r_out_valid;

  // Decode owns every field except pc and inst.
  always_comb begin
    if_de_cword      = '0;
    if_de_cword.pc   = r_out_pc;
    if_de_cword.inst = r_out_inst;
  end

`ifdef IF_PERF_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_bubbles;

  // Delivered-instruction and bubble counters, wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_fetched <= '0;
      r_perf_bubbles <= '0;
    end else if (redirect_valid) begin
      r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end else if (!stall) begin
      if (w_have_head) r_perf_fetched <= r_perf_fetched + 32'd1;
      else             r_perf_bubbles <= r_perf_bubbles + 32'd1;
    end
  end

  assign perf_fetched = r_perf_fetched;
  assign perf_bubbles = r_perf_bubbles;
`else
  assign perf_fetched = '0;
  assign perf_bubbles = '0;
`endif

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction fetch stage: holds the fetch PC, issues single-outstanding requests to instruction memory, buffers returned words and produces if_de_cword for decode.
- Sits between the instruction memory port and decode; obeys the same stall as decode.
- Accepts PC redirects (taken branch/JAL/JALR) from downstream and discards wrong-path work.
- Fills only the pc and inst fields of rvga_cword; decode fills the rest.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- BUF_DEPTH, 2, entries in the fetch buffer of {pc, inst}; power of 2, >= 2.
- NOP_INST, 32'h0000_0013, bubble instruction (ADDI x0,x0,0).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold if_de_cword, no pop from buffer.
- redirect_valid  in  1  single-cycle redirect strobe.
- redirect_pc  in  32  new fetch address; bits [1:0] forced to 0.
- imem_req  out  1  request valid; held with imem_addr until imem_ack.
- imem_addr  out  32  word-aligned fetch address.
- imem_ack  in  1  response strobe; imem_rdata valid this cycle.
- imem_rdata  in  32  fetched instruction.
- if_de_cword  out  rvga_cword  pc and inst set; all other fields 0.
- if_de_valid  out  1  1 = real instruction, 0 = bubble.
- perf_fetched  out  32  count of instructions delivered (optional feature).
- perf_bubbles  out  32  count of bubbles delivered (optional feature).

Behaviour:
- Reset (async): fetch_pc = RESET_PC; buffer empty; state IDLE; imem_req = 0; imem_addr = RESET_PC; if_de_cword = 0 except inst = NOP_INST; if_de_valid = 0; perf counters = 0.
- States:
  - IDLE: assert imem_req with imem_addr = fetch_pc when (occupancy + 0) < BUF_DEPTH; -> WAIT on the same edge.
  - WAIT: imem_req held high, address stable. On imem_ack: push {fetch_pc, imem_rdata}; fetch_pc += 4 (32-bit wrap, 32'hFFFF_FFFC -> 0); -> IDLE. imem_req may drop the cycle after ack.
  - KILL: outstanding request is wrong-path. Keep imem_req high until imem_ack, discard data, -> IDLE.
- Only one request outstanding; no new request in the ack cycle. Max throughput is 1 instruction per 2 cycles with 1-cycle ack.
- Output register: on a clock with ~stall, pop the buffer head into if_de_cword with if_de_valid = 1. If the buffer is empty, load a bubble (inst = NOP_INST, pc = 0, valid = 0). With stall = 1, output and buffer hold; fetching continues until the buffer is full.
- Push and pop in the same cycle are allowed at any occupancy, including full (pop first).
- Redirect (highest priority, ignores stall):
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - Buffer flushed; output register loaded with a bubble.
  - IDLE -> IDLE, next request at the new PC on the next cycle.
  - WAIT without ack same cycle -> KILL.
  - WAIT with ack same cycle -> data dropped, -> IDLE.
  - KILL -> KILL with fetch_pc updated.
- Redirect and stall together: the bubble still loads; stall then holds the bubble.

Optional Feature:
- IF_PERF_EN defined: perf_fetched increments on each ~stall cycle that loads a valid instruction; perf_bubbles increments on each ~stall cycle, or redirect, that loads a bubble. Both are 32-bit wrapping and reset to 0.
- IF_PERF_EN undefined: both ports are tied to 0 and no counter logic exists.

Test Plan:
- Reset release, imem_ack 1 cycle after every req, rdata = 0x00500093, 0x00100113 -> imem_addr 0x0 then 0x4; if_de_cword shows pc 0x0 then 0x4 in order, with bubbles between.
- stall = 1 for 6 cycles with an acking memory -> exactly 2 requests accepted (buffer full), imem_req low afterwards; if_de_cword unchanged; after release, pc 0x0/0x4 delivered on consecutive cycles.
- Redirect to 0x103 while in WAIT with ack delayed 3 cycles -> response discarded; next imem_addr = 0x100; bubble output with valid 0.
- Redirect in the same cycle as imem_ack of 0x8 -> no push of 0x8; next request at redirect_pc; if_de_valid never shows pc 0x8.
- Assert rst_n low mid-WAIT -> imem_req low immediately (async); after release, imem_addr = RESET_PC.
- With IF_PERF_EN: 4 delivered instructions and 3 bubbles -> perf_fetched = 4, perf_bubbles = 3. Without IF_PERF_EN: both stay 0.
